// File: rtl/pipe_stage_skid_pkg.sv
// Shared types and constants for the skid-buffered pipeline stage.
// Field positions describe the ID/EX control bundle layout.
package pipe_pkg;

  localparam int CTRL_W_DEF = 16;
  localparam int DATA_W_DEF = 32;
  localparam int N_DATA_DEF = 3;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  // ID/EX control bundle bit positions
  localparam int IDEX_REGWRITE  = 0;
  localparam int IDEX_MEMTOREG  = 1;
  localparam int IDEX_MEMWRITE  = 2;
  localparam int IDEX_BRANCH    = 3;
  localparam int IDEX_ALUCTL_LO = 4;
  localparam int IDEX_ALUCTL_W  = 2;
  localparam int IDEX_COND_LO   = 6;
  localparam int IDEX_COND_W    = 4;
  localparam int IDEX_WA3_LO    = 10;
  localparam int IDEX_WA3_W     = 4;

endpackage

// File: rtl/pipe_stage_skid_if.sv
// Handshake bundle between an upstream producer, the stage and a downstream consumer.
// master = the side driving the stage inputs; slave = the stage itself.
interface pipe_stage_skid_if
  import pipe_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int N_DATA = N_DATA_DEF
) ();

  logic                     flush;
  logic                     in_valid;
  logic                     in_ready;
  logic [CTRL_W-1:0]        in_ctrl;
  logic [N_DATA*DATA_W-1:0] in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [CTRL_W-1:0]        out_ctrl;
  logic [N_DATA*DATA_W-1:0] out_data;
  logic [1:0]               occupancy;

  modport master (
    output flush, in_valid, in_ctrl, in_data, out_ready,
    input  in_ready, out_valid, out_ctrl, out_data, occupancy
  );

  modport slave (
    input  flush, in_valid, in_ctrl, in_data, out_ready,
    output in_ready, out_valid, out_ctrl, out_data, occupancy
  );

endinterface

// File: rtl/pipe_stage_skid_slot.sv
// One storage slot: valid flag plus ctrl/data payload registers.
// clear wins over load; payload only updates on an effective load.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int PAY_W  = DATA_W_DEF * N_DATA_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [PAY_W-1:0]  data_i,
  output logic              valid_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [PAY_W-1:0]  data_o
);

  logic              valid_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [PAY_W-1:0]  data_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
    end else begin
      if (clear_i) begin
        valid_q <= 1'b0;
      end else if (load_i) begin
        valid_q <= 1'b1;
        ctrl_q  <= ctrl_i;
        data_q  <= data_i;
      end
    end
  end

  assign valid_o = valid_q;
  assign ctrl_o  = ctrl_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline-stage register with a 2-entry skid buffer, registered in_ready and flush.
// MAIN feeds the outputs; SKID absorbs the one entry accepted while downstream stalls.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int N_DATA = N_DATA_DEF
) (
  input  logic              clk,
  input  logic              rst,
  pipe_stage_skid_if.slave  bus
);

  localparam int PAY_W = N_DATA * DATA_W;

  state_t             state_q, state_d;
  logic               in_ready_q;
  logic               in_fire, out_fire;
  logic               main_load, main_clear, main_from_skid;
  logic               skid_load, skid_clear;
  logic               main_valid, skid_valid;
  logic [CTRL_W-1:0]  main_ctrl, skid_ctrl, main_ld_ctrl;
  logic [PAY_W-1:0]   main_data, skid_data, main_ld_data;

  assign in_fire  = bus.in_valid & in_ready_q;
  assign out_fire = main_valid & bus.out_ready;

  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_clear     = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clear     = 1'b0;
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          main_load = 1'b1;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        if (in_fire && out_fire) begin
          main_load = 1'b1;
        end else if (in_fire) begin
          skid_load = 1'b1;
          state_d   = FULL;
        end else if (out_fire) begin
          main_clear = 1'b1;
          state_d    = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          main_load      = 1'b1;
          main_from_skid = 1'b1;
          skid_clear     = 1'b1;
          state_d        = BUSY;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush overrides everything, including a same-cycle accept.
    if (bus.flush) begin
      main_load  = 1'b0;
      skid_load  = 1'b0;
      main_clear = 1'b1;
      skid_clear = 1'b1;
      state_d    = EMPTY;
    end
  end

  assign main_ld_ctrl = main_from_skid ? skid_ctrl : bus.in_ctrl;
  assign main_ld_data = main_from_skid ? skid_data : bus.in_data;

  // in_ready mirrors "SKID will be empty", held low through reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != FULL);
    end
  end

  pipe_slot #(.CTRL_W(CTRL_W), .PAY_W(PAY_W)) u_main (
    .clk     (clk),
    .rst     (rst),
    .load_i  (main_load),
    .clear_i (main_clear),
    .ctrl_i  (main_ld_ctrl),
    .data_i  (main_ld_data),
    .valid_o (main_valid),
    .ctrl_o  (main_ctrl),
    .data_o  (main_data)
  );

  pipe_slot #(.CTRL_W(CTRL_W), .PAY_W(PAY_W)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .load_i  (skid_load),
    .clear_i (skid_clear),
    .ctrl_i  (bus.in_ctrl),
    .data_i  (bus.in_data),
    .valid_o (skid_valid),
    .ctrl_o  (skid_ctrl),
    .data_o  (skid_data)
  );

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = main_valid;
  assign bus.out_ctrl  = main_valid ? main_ctrl : '0;
  assign bus.out_data  = main_data;
  assign bus.occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: reset, streaming, stall/skid, flush and async reset.
module tb_pipe_stage_skid;
  import pipe_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_total = 0;
  int   n_pass  = 0;

  pipe_stage_skid_if #(.CTRL_W(16), .DATA_W(32), .N_DATA(3)) bus ();

  pipe_stage_skid #(.CTRL_W(16), .DATA_W(32), .N_DATA(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
      $display("check %-14s obs=%0h exp=%0h ok", tag, obs, exp);
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] c, input logic [95:0] d);
    bus.in_valid = v;
    bus.in_ctrl  = c;
    bus.in_data  = d;
  endtask

  initial begin
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, 16'h0, 96'h0);

    // 1. reset and single transfer
    #2;
    chk("rst_in_ready", 128'(bus.in_ready), 128'd0);
    chk("rst_out_valid", 128'(bus.out_valid), 128'd0);
    chk("rst_out_ctrl", 128'(bus.out_ctrl), 128'd0);
    chk("rst_out_data", 128'(bus.out_data), 128'd0);
    chk("rst_occ", 128'(bus.occupancy), 128'd0);
    tick(); tick(); tick();
    chk("rst_hold_rdy", 128'(bus.in_ready), 128'd0);
    rst = 1'b1;
    tick();
    chk("rdy_after_rst", 128'(bus.in_ready), 128'd1);
    bus.out_ready = 1'b1;
    drive(1'b1, 16'h00A5, {32'h1, 32'h2, 32'h3});
    tick();
    drive(1'b0, 16'h0, 96'h0);
    chk("t1_valid", 128'(bus.out_valid), 128'd1);
    chk("t1_ctrl", 128'(bus.out_ctrl), 128'h00A5);
    chk("t1_data", 128'(bus.out_data), 128'({32'h1, 32'h2, 32'h3}));
    chk("t1_occ", 128'(bus.occupancy), 128'd1);
    tick();
    chk("t1_bubble_v", 128'(bus.out_valid), 128'd0);
    chk("t1_bubble_c", 128'(bus.out_ctrl), 128'd0);
    chk("t1_data_hold", 128'(bus.out_data), 128'({32'h1, 32'h2, 32'h3}));

    // 2. streaming
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 16'(16'h0100 + i), {64'h0, 32'(i)});
      tick();
      chk("strm_word0", 128'(bus.out_data[31:0]), 128'(i));
      chk("strm_valid", 128'(bus.out_valid), 128'd1);
      chk("strm_ready", 128'(bus.in_ready), 128'd1);
    end
    drive(1'b0, 16'h0, 96'h0);
    tick();
    chk("strm_drain", 128'(bus.out_valid), 128'd0);

    // 3. stall into skid
    bus.out_ready = 1'b0;
    drive(1'b1, 16'h0011, {64'h0, 32'hA});
    tick();
    chk("stall_a_ctrl", 128'(bus.out_ctrl), 128'h0011);
    chk("stall_a_occ", 128'(bus.occupancy), 128'd1);
    drive(1'b1, 16'h0022, {64'h0, 32'hB});
    tick();
    chk("stall_occ2", 128'(bus.occupancy), 128'd2);
    chk("stall_rdy0", 128'(bus.in_ready), 128'd0);
    chk("stall_hold_a", 128'(bus.out_data[31:0]), 128'hA);
    drive(1'b1, 16'h0033, {64'h0, 32'hC});
    tick();
    chk("stall_c_rej", 128'(bus.occupancy), 128'd2);
    chk("stall_hold_a2", 128'(bus.out_ctrl), 128'h0011);
    bus.out_ready = 1'b1;
    tick();
    chk("drain_b_data", 128'(bus.out_data[31:0]), 128'hB);
    chk("drain_b_ctrl", 128'(bus.out_ctrl), 128'h0022);
    chk("drain_b_occ", 128'(bus.occupancy), 128'd1);
    chk("drain_rdy1", 128'(bus.in_ready), 128'd1);
    tick();
    drive(1'b0, 16'h0, 96'h0);
    chk("drain_c_data", 128'(bus.out_data[31:0]), 128'hC);
    chk("drain_c_ctrl", 128'(bus.out_ctrl), 128'h0033);
    tick();
    chk("drain_empty", 128'(bus.out_valid), 128'd0);
    chk("drain_occ0", 128'(bus.occupancy), 128'd0);

    // 4. flush while FULL with in_valid=1, then flush in BUSY with an accept
    bus.out_ready = 1'b0;
    drive(1'b1, 16'h0044, {64'h0, 32'hD});
    tick();
    drive(1'b1, 16'h0055, {64'h0, 32'hE});
    tick();
    chk("pre_flush_occ", 128'(bus.occupancy), 128'd2);
    drive(1'b1, 16'h0066, {64'h0, 32'hF});
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    drive(1'b0, 16'h0, 96'h0);
    chk("flush_valid", 128'(bus.out_valid), 128'd0);
    chk("flush_ctrl", 128'(bus.out_ctrl), 128'd0);
    chk("flush_occ", 128'(bus.occupancy), 128'd0);
    chk("flush_rdy", 128'(bus.in_ready), 128'd1);
    drive(1'b1, 16'h0077, {64'h0, 32'h10});
    tick();
    chk("busy_occ1", 128'(bus.occupancy), 128'd1);
    drive(1'b1, 16'h0088, {64'h0, 32'h11});
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    drive(1'b0, 16'h0, 96'h0);
    chk("flush_b_occ", 128'(bus.occupancy), 128'd0);
    tick();
    chk("flush_b_noleak", 128'(bus.out_valid), 128'd0);
    chk("flush_b_ctrl", 128'(bus.out_ctrl), 128'd0);

    // 5. flush coinciding with out_fire
    bus.out_ready = 1'b1;
    drive(1'b1, 16'h0099, {64'h0, 32'h12});
    tick();
    drive(1'b0, 16'h0, 96'h0);
    chk("ff_main_ctrl", 128'(bus.out_ctrl), 128'h0099);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("ff_bubble_v", 128'(bus.out_valid), 128'd0);
    chk("ff_bubble_c", 128'(bus.out_ctrl), 128'd0);
    tick();
    chk("ff_no_repeat", 128'(bus.out_valid), 128'd0);

    // 6. asynchronous reset while FULL
    bus.out_ready = 1'b0;
    drive(1'b1, 16'h00AA, {64'h0, 32'h13});
    tick();
    drive(1'b1, 16'h00BB, {64'h0, 32'h14});
    tick();
    drive(1'b0, 16'h0, 96'h0);
    chk("pre_arst_occ", 128'(bus.occupancy), 128'd2);
    #2 rst = 1'b0;
    #1;
    chk("arst_valid", 128'(bus.out_valid), 128'd0);
    chk("arst_ctrl", 128'(bus.out_ctrl), 128'd0);
    chk("arst_data", 128'(bus.out_data), 128'd0);
    chk("arst_occ", 128'(bus.occupancy), 128'd0);
    chk("arst_rdy", 128'(bus.in_ready), 128'd0);
    tick();
    rst = 1'b1;
    tick();
    chk("post_arst_rdy", 128'(bus.in_ready), 128'd1);
    chk("post_arst_v", 128'(bus.out_valid), 128'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised pipeline-stage register with a valid/ready handshake, a 2-entry skid buffer and synchronous flush.
- Carries a control bundle and N data words between CPU stages (ID/EX, EX/MEM, MEM/WB).
- Allows a downstream stall without a combinational ready path back upstream.
- Inserts bubbles on flush: control fields are zero whenever the output is invalid.

Parameters:
- CTRL_W, 16, width of the packed control bundle (RegWrite, MemtoReg, ALUControl, Branch, cond, WA3, ...).
- DATA_W, 32, width of one data word.
- N_DATA, 3, number of data words carried (e.g. rd1, rd2, ExtImm).

Ports:
- clk  in  1  stage clock; all state captured on the rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- flush  in  1  synchronous kill of all held entries.
- in_valid  in  1  upstream entry present.
- in_ready  out  1  stage can accept this cycle; registered.
- in_ctrl  in  CTRL_W  upstream control bundle.
- in_data  in  N_DATA*DATA_W  upstream data words; word k at bits [k*DATA_W +: DATA_W].
- out_valid  out  1  output entry present.
- out_ready  in  1  downstream accepts this cycle.
- out_ctrl  out  CTRL_W  control to next stage; forced to 0 when out_valid=0.
- out_data  out  N_DATA*DATA_W  data to next stage.
- occupancy  out  2  entries held: 0, 1 or 2.

Behaviour:
- Storage: two slots.
  - MAIN drives the outputs.
  - SKID holds one overflow entry.
  - Each slot has a valid bit plus ctrl/data registers.
- States: EMPTY (MAIN invalid), BUSY (MAIN valid, SKID invalid), FULL (both valid).
- Handshakes: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- in_ready = !SKID.valid, taken directly from a flop. It is 1 in EMPTY/BUSY and 0 in FULL.
- State transitions (flush=0):
  - EMPTY: in_fire -> MAIN<=in, go to BUSY.
  - BUSY, in_fire & out_fire -> MAIN<=in, stay BUSY.
  - BUSY, in_fire & !out_ready -> SKID<=in, go to FULL.
  - BUSY, out_fire & !in_fire -> go to EMPTY.
  - FULL: out_fire -> MAIN<=SKID, SKID invalid, go to BUSY. No input is accepted in FULL.
- Latency is 1 cycle from in_fire to out_valid when EMPTY. Sustained throughput is 1 entry/cycle with out_ready=1.
- Ordering is strict FIFO; no entry is duplicated or lost except by flush.
- Output stability: while out_valid=1 and out_ready=0, out_ctrl and out_data hold.
- Flush:
  - Highest priority. On the next edge both valid bits clear and the state becomes EMPTY.
  - An in_fire in the same cycle is discarded; upstream treats it as consumed.
  - A simultaneous out_fire completes downstream; it is not repeated.
- Bubble: out_ctrl = MAIN.ctrl when MAIN.valid, else all zeros.
  - Ensures RegWrite/MemWrite/Branch never leak from an invalid slot.
  - out_data is not gated; it holds its last value.
- occupancy = MAIN.valid + SKID.valid.
- Reset (rst=0, asynchronous):
  - All valid bits, ctrl and data registers clear to 0; state EMPTY.
  - Outputs: out_valid=0, out_ctrl=0, out_data=0, occupancy=0.
  - in_ready=0 while rst=0; it rises on the first rising clk edge after release.
  - Reset mid-transfer drops all entries.
- Width rules: no arithmetic; all transfers are bit-exact copies. CTRL_W >= 1, N_DATA >= 1.

Decomposition:
- Package pipe_pkg:
  - State enum typedef {EMPTY, BUSY, FULL}.
  - Localparams for default CTRL_W/DATA_W/N_DATA.
  - Bit-position constants for the ID/EX control bundle fields.
- Sub-module pipe_slot (parametrised):
  - Contains a valid flop and ctrl/data registers.
  - Inputs: load, clear, and load data.
  - Instantiated twice (MAIN, SKID).

Test Plan:
1. Reset and single transfer.
   - Stimulus: hold rst=0 for 3 cycles, release, then push ctrl=16'h00A5, data={32'h1,32'h2,32'h3}, out_ready=1.
   - Response: in_ready=0 during reset and 1 after the first edge. out_valid=1 with exact values 1 cycle after in_fire, occupancy=1.
2. Streaming.
   - Stimulus: 8 back-to-back entries with data word0 = 0..7, out_ready=1.
   - Response: output word0 = 0..7 in order on consecutive cycles, in_ready constantly 1.
3. Stall into skid.
   - Stimulus: out_ready=0, push A then B.
   - Response: out shows A and holds. occupancy=2, in_ready=0. C is not accepted.
   - Then: raise out_ready.
   - Response: A, B, C delivered in order; no loss or duplication.
4. Flush while FULL with in_valid=1.
   - Response: next cycle out_valid=0, out_ctrl=0, occupancy=0. The flushed-cycle input never appears at the output.
5. Flush and out_fire simultaneous.
   - Response: the MAIN entry is counted delivered once; the following cycle is a bubble with out_ctrl=0.
6. Reset mid-stream.
   - Stimulus: rst=0 asynchronously while FULL.
   - Response: out_valid, out_ctrl and out_data go to 0 immediately, without a clock edge.
